// File: rtl/pxs_score_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : pxs_score_controller_pkg
//  Purpose : Shared types and helpers for the score sequencer. It holds the
//            pixel-stream field layout, the 2-bit game-state encodings, the
//            winner codes and a saturating score increment.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package pxs_score_controller_pkg;

  // Pixel stream layout: {XC[9:0], YC[9:0], colour[5:0]}
  localparam int STR_W   = 26;
  localparam int COORD_W = 10;
  localparam int XC_LSB  = 16;
  localparam int YC_LSB  = 6;
  localparam int COL_W   = 6;

  localparam logic [7:0] SCORE_MAX = 8'd99;

  // Game-state encodings
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PLAY  = 2'b01,
    ST_PAUSE = 2'b10,
    ST_OVER  = 2'b11
  } state_t;

  // Winner codes: bit0 = player 1, bit1 = player 2
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  // min(score + inc, 99)
  function automatic logic [7:0] sat_inc(input logic [7:0] score, input logic inc);
    logic [7:0] res;
    res = score;
    if (inc) begin
      if (score >= SCORE_MAX) res = SCORE_MAX;
      else                    res = score + 8'd1;
    end
    return res;
  endfunction

endpackage : pxs_score_controller_pkg
`default_nettype wire

// File: rtl/pxs_frame_tick.sv
`default_nettype none
// ============================================================================
//  Module  : pxs_frame_tick
//  Purpose : Decodes the pixel stream coordinates and raises a one-pixel tick
//            when the stream sits at (COL, ROW). It is purely combinational,
//            so the tick is aligned with the pixel it decodes.
//  Ports   : rgb_str  in  26  pixel stream (XC / YC fields used)
//            tick     out  1  high while XC==COL and YC==ROW
//  Rev     : 1.0  initial release
// ============================================================================
module pxs_frame_tick
  import pxs_score_controller_pkg::*;
#(
  parameter int COL = 638,
  parameter int ROW = 479
) (
  input  logic [STR_W-1:0] rgb_str,
  output logic             tick
);

  localparam logic [COORD_W-1:0] TICK_COL = COORD_W'(COL);
  localparam logic [COORD_W-1:0] TICK_ROW = COORD_W'(ROW);

  logic [COORD_W-1:0] xc;
  logic [COORD_W-1:0] yc;
  logic               unused_colour;

  assign xc = rgb_str[XC_LSB +: COORD_W];
  assign yc = rgb_str[YC_LSB +: COORD_W];

  // Colour bits travel in the same bus but carry no timing information.
  assign unused_colour = ^rgb_str[COL_W-1:0];

  assign tick = (xc == TICK_COL) && (yc == TICK_ROW);

endmodule : pxs_frame_tick
`default_nettype wire

// File: rtl/pxs_score_controller.sv
`default_nettype none
// ============================================================================
//  Module  : pxs_score_controller
//  Purpose : Per-game score sequencer beside the score overlay chain. It
//            collects point pulses, runs the IDLE/PLAY/PAUSE/OVER game FSM
//            and commits the binary scores one pixel before the overlay's
//            end-of-frame latch, so displayed digits never change mid-frame.
//  Ports   : px_clk       in   1  pixel clock
//            rst_n        in   1  asynchronous active-low reset
//            RGBStr_i     in  26  pixel stream (XC / YC used)
//            point_p1     in   1  pulse: player 1 scored
//            point_p2     in   1  pulse: player 2 scored
//            new_game     in   1  pulse: restart game (highest priority)
//            score1       out  8  player 1 score, 0..99
//            score2       out  8  player 2 score, 0..99
//            serve_pause  out  1  high whenever the game is not in PLAY
//            game_over    out  1  high in OVER
//            winner       out  2  01 P1, 10 P2, 11 tie, 00 none
//  Rev     : 1.0  initial release
// ============================================================================
module pxs_score_controller
  import pxs_score_controller_pkg::*;
#(
  parameter int WIN_SCORE    = 11,
  parameter int PAUSE_FRAMES = 60,
  parameter int VISIBLECOLS  = 640,
  parameter int VISIBLEROWS  = 480
) (
  input  logic             px_clk,
  input  logic             rst_n,
  input  logic [STR_W-1:0] RGBStr_i,
  input  logic             point_p1,
  input  logic             point_p2,
  input  logic             new_game,
  output logic [7:0]       score1,
  output logic [7:0]       score2,
  output logic             serve_pause,
  output logic             game_over,
  output logic [1:0]       winner
);

  localparam int              CNT_W    = $clog2(PAUSE_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PAUSE_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [7:0]       WIN_VAL  = 8'(WIN_SCORE);

  state_t           state, state_n;
  logic [7:0]       score1_n, score2_n;
  logic             pend1, pend1_n;
  logic             pend2, pend2_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       winner_n;
  logic             serve_pause_n;
  logic             game_over_n;

  logic             commit;
  logic [7:0]       sum1, sum2;
  logic             reach1, reach2;

  // Commit one pixel before the overlay latches its digits at end of frame.
  pxs_frame_tick #(
    .COL (VISIBLECOLS - 2),
    .ROW (VISIBLEROWS - 1)
  ) u_frame_tick (
    .rgb_str (RGBStr_i),
    .tick    (commit)
  );

  assign sum1   = sat_inc(score1, pend1);
  assign sum2   = sat_inc(score2, pend2);
  assign reach1 = (sum1 >= WIN_VAL);
  assign reach2 = (sum2 >= WIN_VAL);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      score1      <= 8'd0;
      score2      <= 8'd0;
      pend1       <= 1'b0;
      pend2       <= 1'b0;
      cnt         <= '0;
      winner      <= WIN_NONE;
      serve_pause <= 1'b1;
      game_over   <= 1'b0;
    end else begin
      state       <= state_n;
      score1      <= score1_n;
      score2      <= score2_n;
      pend1       <= pend1_n;
      pend2       <= pend2_n;
      cnt         <= cnt_n;
      winner      <= winner_n;
      serve_pause <= serve_pause_n;
      game_over   <= game_over_n;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state / next-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_n  = state;
    score1_n = score1;
    score2_n = score2;
    pend1_n  = pend1;
    pend2_n  = pend2;
    cnt_n    = cnt;
    winner_n = winner;

    if (new_game) begin
      // Restart wins over anything else, including a coincident commit.
      state_n  = ST_PAUSE;
      score1_n = 8'd0;
      score2_n = 8'd0;
      pend1_n  = 1'b0;
      pend2_n  = 1'b0;
      cnt_n    = CNT_LOAD;
      winner_n = WIN_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          state_n = ST_IDLE;
        end

        ST_PLAY: begin
          if (commit && (pend1 || pend2)) begin
            score1_n = sum1;
            score2_n = sum2;
            pend1_n  = 1'b0;
            pend2_n  = 1'b0;
            if (reach1 || reach2) begin
              state_n  = ST_OVER;
              winner_n = {reach2, reach1};
            end else begin
              cnt_n   = CNT_LOAD;
              state_n = ST_PAUSE;
            end
          end
          // A pulse on the commit edge itself overrides the clear above and
          // is therefore scored in the following frame.
          if (point_p1) pend1_n = 1'b1;
          if (point_p2) pend2_n = 1'b1;
        end

        ST_PAUSE: begin
          if (commit) begin
            if (cnt <= CNT_ONE) begin
              cnt_n   = '0;
              state_n = ST_PLAY;
            end else begin
              cnt_n = cnt - CNT_ONE;
            end
          end
        end

        ST_OVER: begin
          state_n = ST_OVER;
        end

        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end

    serve_pause_n = (state_n != ST_PLAY);
    game_over_n   = (state_n == ST_OVER);
  end

endmodule : pxs_score_controller
`default_nettype wire

// File: tb/tb_pxs_score_controller.sv
`default_nettype none
// ============================================================================
//  Module  : tb_pxs_score_controller
//  Purpose : Self-checking bench for pxs_score_controller on a reduced raster
//            (16x8 visible inside a 20x10 total frame), WIN_SCORE=3 and
//            PAUSE_FRAMES=2.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_pxs_score_controller;
  import pxs_score_controller_pkg::*;

  localparam int COLS   = 16;
  localparam int ROWS   = 8;
  localparam int TCOLS  = 20;
  localparam int TROWS  = 10;
  localparam int FRAME  = TCOLS * TROWS;
  localparam int CMT_X  = COLS - 2;
  localparam int CMT_Y  = ROWS - 1;
  localparam int MID_X  = 5;
  localparam int MID_Y  = 3;

  logic             clk;
  logic             rst_n;
  logic [STR_W-1:0] rgb;
  logic             point_p1, point_p2, new_game;
  logic [7:0]       score1, score2;
  logic             serve_pause, game_over;
  logic [1:0]       winner;

  int xc, yc;
  int checks, errors;

  pxs_score_controller #(
    .WIN_SCORE    (3),
    .PAUSE_FRAMES (2),
    .VISIBLECOLS  (COLS),
    .VISIBLEROWS  (ROWS)
  ) dut (
    .px_clk      (clk),
    .rst_n       (rst_n),
    .RGBStr_i    (rgb),
    .point_p1    (point_p1),
    .point_p2    (point_p2),
    .new_game    (new_game),
    .score1      (score1),
    .score2      (score2),
    .serve_pause (serve_pause),
    .game_over   (game_over),
    .winner      (winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       p1;
    bit       p2;
    bit       ng;
    int       rep;
    int       s1;
    int       s2;
    bit       sp;
    bit       go;
    bit [1:0] w;
  } vec_t;

  vec_t vecs[26];

  function automatic vec_t mk(bit p1, bit p2, bit ng, int rep, int s1, int s2,
                              bit sp, bit go, bit [1:0] w);
    vec_t v;
    v.p1 = p1; v.p2 = p2; v.ng = ng; v.rep = rep;
    v.s1 = s1; v.s2 = s2; v.sp = sp; v.go = go; v.w = w;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_rgb();
    logic [31:0] x, y;
    x = xc;
    y = yc;
    rgb = '0;
    rgb[XC_LSB +: COORD_W] = x[COORD_W-1:0];
    rgb[YC_LSB +: COORD_W] = y[COORD_W-1:0];
    rgb[COL_W-1:0]         = x[5:0] ^ y[5:0];
  endtask

  // One pixel: wait for the edge, then clear pulses and move the raster.
  task automatic adv();
    @(posedge clk);
    #1;
    point_p1 = 1'b0;
    point_p2 = 1'b0;
    new_game = 1'b0;
    xc++;
    if (xc == TCOLS) begin
      xc = 0;
      yc++;
      if (yc == TROWS) yc = 0;
    end
    drive_rgb();
  endtask

  task automatic goto_px(input int x, input int y);
    int n;
    n = 0;
    while (!(xc == x && yc == y) && n < FRAME + 2) begin
      adv();
      n++;
    end
    if (!(xc == x && yc == y)) begin
      errors++;
      $display("FAIL raster_sync: got %0d,%0d expected %0d,%0d", xc, yc, x, y);
    end
  endtask

  // Run up to and across the commit edge.
  task automatic pass_commit();
    goto_px(CMT_X, CMT_Y);
    adv();
  endtask

  task automatic chk_out(input string tag, input int s1, input int s2,
                         input bit sp, input bit go, input bit [1:0] w);
    chk({tag, ".score1"},      32'(score1),      32'(s1));
    chk({tag, ".score2"},      32'(score2),      32'(s2));
    chk({tag, ".serve_pause"}, 32'(serve_pause), 32'(sp));
    chk({tag, ".game_over"},   32'(game_over),   32'(go));
    chk({tag, ".winner"},      32'(winner),      32'(w));
  endtask

  // score1 may only move on a commit edge, a new_game edge or a reset.
  logic [7:0] prev_s1;
  bit         rst_event;
  bit         allow;
  initial begin
    prev_s1   = 8'd0;
    rst_event = 1'b1;
  end
  always @(negedge rst_n) rst_event = 1'b1;
  always @(posedge clk) begin
    allow = ((xc == CMT_X) && (yc == CMT_Y)) || new_game;
    #1;
    if (score1 !== prev_s1) begin
      checks++;
      if (!allow && !rst_event) begin
        errors++;
        $display("FAIL score1_stable: got %0d expected %0d (t=%0t)", score1, prev_s1, $time);
      end
    end
    prev_s1   = score1;
    rst_event = 1'b0;
  end

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b1;
    point_p1 = 1'b0;
    point_p2 = 1'b0;
    new_game = 1'b0;
    xc       = 0;
    yc       = 0;
    drive_rgb();

    //            p1 p2 ng rep s1 s2 sp go w
    vecs[0]  = mk(0, 0, 0, 1, 0, 0, 1, 0, WIN_NONE); // idle frames
    vecs[1]  = mk(0, 0, 0, 1, 0, 0, 1, 0, WIN_NONE);
    vecs[2]  = mk(0, 0, 0, 1, 0, 0, 1, 0, WIN_NONE);
    vecs[3]  = mk(0, 0, 1, 1, 0, 0, 1, 0, WIN_NONE); // new game: pause 1st commit
    vecs[4]  = mk(1, 0, 0, 1, 0, 0, 0, 0, WIN_NONE); // p1 in pause ignored, 2nd commit -> play
    vecs[5]  = mk(1, 0, 0, 1, 1, 0, 1, 0, WIN_NONE); // p1 scores
    vecs[6]  = mk(0, 0, 0, 1, 1, 0, 1, 0, WIN_NONE);
    vecs[7]  = mk(0, 0, 0, 1, 1, 0, 0, 0, WIN_NONE);
    vecs[8]  = mk(1, 1, 0, 1, 2, 1, 1, 0, WIN_NONE); // both same cycle
    vecs[9]  = mk(0, 0, 0, 1, 2, 1, 1, 0, WIN_NONE);
    vecs[10] = mk(0, 0, 0, 1, 2, 1, 0, 0, WIN_NONE);
    vecs[11] = mk(0, 1, 0, 3, 2, 2, 1, 0, WIN_NONE); // three p2 pulses -> +1
    vecs[12] = mk(0, 0, 0, 1, 2, 2, 1, 0, WIN_NONE);
    vecs[13] = mk(0, 0, 0, 1, 2, 2, 0, 0, WIN_NONE);
    vecs[14] = mk(1, 1, 0, 1, 3, 3, 1, 1, WIN_TIE);  // both reach 3 -> tie
    vecs[15] = mk(1, 0, 0, 1, 3, 3, 1, 1, WIN_TIE);  // frozen in over
    vecs[16] = mk(0, 1, 0, 3, 3, 3, 1, 1, WIN_TIE);
    vecs[17] = mk(0, 0, 1, 1, 0, 0, 1, 0, WIN_NONE); // restart from over
    vecs[18] = mk(0, 0, 0, 1, 0, 0, 0, 0, WIN_NONE);
    vecs[19] = mk(0, 1, 0, 1, 0, 1, 1, 0, WIN_NONE);
    vecs[20] = mk(0, 0, 0, 1, 0, 1, 1, 0, WIN_NONE);
    vecs[21] = mk(0, 0, 0, 1, 0, 1, 0, 0, WIN_NONE);
    vecs[22] = mk(0, 1, 0, 1, 0, 2, 1, 0, WIN_NONE);
    vecs[23] = mk(0, 0, 0, 1, 0, 2, 1, 0, WIN_NONE);
    vecs[24] = mk(0, 0, 0, 1, 0, 2, 0, 0, WIN_NONE);
    vecs[25] = mk(0, 1, 0, 1, 0, 3, 1, 1, WIN_P2);   // player 2 wins alone

    // Reset values, asserted away from a clock edge
    #2 rst_n = 1'b0;
    #1;
    chk_out("reset", 0, 0, 1'b1, 1'b0, WIN_NONE);
    adv();
    adv();
    adv();
    #2 rst_n = 1'b1;

    // Table-driven frames: pulses mid-frame, then check after the commit
    for (int i = 0; i < 26; i++) begin
      goto_px(MID_X, MID_Y);
      for (int r = 0; r < vecs[i].rep; r++) begin
        point_p1 = vecs[i].p1;
        point_p2 = vecs[i].p2;
        new_game = vecs[i].ng;
        adv();
        adv();
      end
      pass_commit();
      chk_out($sformatf("vec%0d", i), vecs[i].s1, vecs[i].s2,
              vecs[i].sp, vecs[i].go, vecs[i].w);
    end

    // Point pulse on the commit edge is scored one frame later
    goto_px(MID_X, MID_Y);
    new_game = 1'b1;
    adv();
    pass_commit();
    pass_commit();
    chk("edge_pt.play", 32'(serve_pause), 32'(0));
    goto_px(CMT_X, CMT_Y);
    point_p1 = 1'b1;
    adv();
    chk("edge_pt.same_commit_s1", 32'(score1), 32'(0));
    chk("edge_pt.same_commit_sp", 32'(serve_pause), 32'(0));
    pass_commit();
    chk("edge_pt.next_commit_s1", 32'(score1), 32'(1));
    chk("edge_pt.next_commit_sp", 32'(serve_pause), 32'(1));

    // new_game coinciding with a commit that has a pending point
    pass_commit();
    pass_commit();
    chk("edge_ng.play", 32'(serve_pause), 32'(0));
    goto_px(MID_X, MID_Y);
    point_p2 = 1'b1;
    adv();
    goto_px(CMT_X, CMT_Y);
    new_game = 1'b1;
    adv();
    chk_out("edge_ng", 0, 0, 1'b1, 1'b0, WIN_NONE);
    pass_commit();
    chk("edge_ng.pause1", 32'(serve_pause), 32'(1));
    pass_commit();
    chk("edge_ng.pause2", 32'(serve_pause), 32'(0));
    pass_commit();
    chk("edge_ng.pend_cleared_s2", 32'(score2), 32'(0));
    chk("edge_ng.pend_cleared_sp", 32'(serve_pause), 32'(0));

    // Asynchronous reset mid-frame
    goto_px(MID_X, MID_Y);
    point_p1 = 1'b1;
    adv();
    pass_commit();
    chk("arst.pre_s1", 32'(score1), 32'(1));
    goto_px(MID_X, MID_Y);
    #2 rst_n = 1'b0;
    #1;
    chk_out("arst", 0, 0, 1'b1, 1'b0, WIN_NONE);
    adv();
    adv();
    #2 rst_n = 1'b1;
    pass_commit();
    chk_out("arst.idle", 0, 0, 1'b1, 1'b0, WIN_NONE);
    goto_px(MID_X, MID_Y);
    new_game = 1'b1;
    adv();
    pass_commit();
    chk("arst.pause1", 32'(serve_pause), 32'(1));
    pass_commit();
    chk("arst.play", 32'(serve_pause), 32'(0));

    adv();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule : tb_pxs_score_controller
`default_nettype wire
